// File: rtl/y86_pkg.sv
// Y86-64 shared definitions: instruction codes, status codes,
// the fetch->decode bundle and instruction length decode.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVQ  = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  localparam logic [3:0] REG_NONE = 4'hF;

  typedef enum logic [1:0] {
    S_RUN,
    S_HALT,
    S_ERR
  } fetch_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
  } if_id_t;

  localparam if_id_t IF_ID_RST = '{
    pc:    64'd0,
    icode: ICODE_NOP,
    ifun:  4'd0,
    ra:    REG_NONE,
    rb:    REG_NONE,
    valc:  64'd0,
    valp:  64'd0,
    stat:  STAT_AOK
  };

  // Undefined icodes get length 1 so the range check still sees the opcode byte.
  function automatic logic [3:0] instr_len(input logic [3:0] icode);
    logic [3:0] len;
    case (icode)
      ICODE_CMOVQ, ICODE_OPQ,
      ICODE_PUSHQ, ICODE_POPQ:    len = 4'd2;
      ICODE_IRMOVQ, ICODE_RMMOVQ,
      ICODE_MRMOVQ:               len = 4'd10;
      ICODE_JXX, ICODE_CALL:      len = 4'd9;
      default:                    len = 4'd1;
    endcase
    return len;
  endfunction

  function automatic logic has_regids(input logic [3:0] icode);
    logic r;
    case (icode)
      ICODE_CMOVQ, ICODE_IRMOVQ, ICODE_RMMOVQ,
      ICODE_MRMOVQ, ICODE_OPQ, ICODE_PUSHQ,
      ICODE_POPQ: r = 1'b1;
      default:    r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fetch_stage_imem.sv
// Byte-wide instruction memory: synchronous write port and a
// combinational 10-byte little-endian read window.
module imem_bytes #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [63:0]   addr,
  output logic [79:0]   window
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // 65-bit addresses so a window near 2^64 cannot wrap back into range.
  for (genvar gi = 0; gi < 10; gi++) begin : g_rd
    logic [64:0] ba;
    assign ba = {1'b0, addr} + 65'(gi);
    assign window[8*gi +: 8] =
      (ba < 65'(DEPTH)) ? mem[ba[AW-1:0]] : 8'h00;
  end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 SEQ fetch stage: PC register, run/halt/error FSM,
// instruction field split and registered outputs to decode.
module fetch_stage
  import y86_pkg::*;
#(
  parameter int IMEM_BYTES = 1024,
  parameter int AW         = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          pc_load,
  input  logic [63:0]   pc_next,
  input  logic          imem_we,
  input  logic [AW-1:0] imem_waddr,
  input  logic [7:0]    imem_wdata,
  output logic [63:0]   pc,
  output logic [3:0]    icode,
  output logic [3:0]    ifun,
  output logic [3:0]    rA,
  output logic [3:0]    rB,
  output logic [63:0]   valC,
  output logic [63:0]   valP,
  output logic          instr_valid,
  output logic [2:0]    stat
);

  fetch_state_e state, nxt_state;

  logic [63:0] pc_q, pc_d;
  logic [79:0] win;
  logic [3:0]  f_len;
  logic [64:0] end_addr;
  logic        adr, ins, hlt;
  logic        load, valid_d, valid_q;
  if_id_t      f, out_q;

  imem_bytes #(
    .DEPTH (IMEM_BYTES),
    .AW    (AW)
  ) u_imem (
    .clk    (clk),
    .we     (imem_we),
    .waddr  (imem_waddr),
    .wdata  (imem_wdata),
    .addr   (pc_q),
    .window (win)
  );

  always_comb begin
    f       = IF_ID_RST;
    f.pc    = pc_q;
    f.icode = win[7:4];
    f.ifun  = win[3:0];
    f_len   = instr_len(f.icode);
    if (has_regids(f.icode)) begin
      f.ra = win[15:12];
      f.rb = win[11:8];
    end
    case (f.icode)
      ICODE_IRMOVQ, ICODE_RMMOVQ,
      ICODE_MRMOVQ:         f.valc = win[79:16];
      ICODE_JXX, ICODE_CALL: f.valc = win[71:8];
      default:              f.valc = 64'd0;
    endcase
    f.valp   = pc_q + 64'(f_len);
    end_addr = {1'b0, pc_q} + 65'(f_len);
    adr      = end_addr > 65'(IMEM_BYTES);
    ins      = f.icode > ICODE_POPQ;
    hlt      = f.icode == ICODE_HALT;
    if (adr)      f.stat = STAT_ADR;
    else if (ins) f.stat = STAT_INS;
    else if (hlt) f.stat = STAT_HLT;
    else          f.stat = STAT_AOK;
  end

  always_comb begin
    nxt_state = state;
    pc_d      = pc_q;
    load      = 1'b0;
    valid_d   = valid_q;
    unique case (state)
      S_RUN: begin
        if (!stall) begin
          load    = 1'b1;
          valid_d = 1'b1;
          if (adr || ins) nxt_state = S_ERR;
          else if (hlt)   nxt_state = S_HALT;
          else            pc_d = pc_load ? pc_next : f.valp;
        end
      end
      S_HALT, S_ERR: valid_d = 1'b0;
      default: nxt_state = S_ERR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_RUN;
    else        state <= nxt_state;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= 64'd0;
      out_q   <= IF_ID_RST;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      if (load) out_q <= f;
    end
  end

  assign pc          = out_q.pc;
  assign icode       = out_q.icode;
  assign ifun        = out_q.ifun;
  assign rA          = out_q.ra;
  assign rB          = out_q.rb;
  assign valC        = out_q.valc;
  assign valP        = out_q.valp;
  assign stat        = out_q.stat;
  assign instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues the expected
// registered outputs for each cycle, a negedge monitor checks them.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        pc_load = 1'b0;
  logic [63:0] pc_next = '0;
  logic        imem_we = 1'b0;
  logic [9:0]  imem_waddr = '0;
  logic [7:0]  imem_wdata = '0;
  logic [63:0] pc, valC, valP;
  logic [3:0]  icode, ifun, rA, rB;
  logic        instr_valid;
  logic [2:0]  stat;

  fetch_stage #(.IMEM_BYTES(1024), .AW(10)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .pc_load(pc_load), .pc_next(pc_next),
    .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata),
    .pc(pc), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP),
    .instr_valid(instr_valid), .stat(stat)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        full;
    logic        v;
    logic [63:0] pc;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp;
    logic [2:0]  stat;
  } exp_t;

  exp_t sb[$];
  exp_t m;
  int total = 0;
  int bad = 0;

  function automatic exp_t mkf(input logic v, input logic [63:0] p,
    input logic [3:0] ic, input logic [3:0] fn,
    input logic [3:0] a, input logic [3:0] b,
    input logic [63:0] c, input logic [63:0] vp, input logic [2:0] s);
    exp_t e;
    e.name = ""; e.full = 1'b1; e.v = v; e.pc = p;
    e.icode = ic; e.ifun = fn; e.ra = a; e.rb = b;
    e.valc = c; e.valp = vp; e.stat = s;
    return e;
  endfunction

  function automatic exp_t mkp(input logic v, input logic [63:0] p,
    input logic [2:0] s);
    exp_t e;
    e = mkf(v, p, 4'h0, 4'h0, 4'h0, 4'h0, 64'h0, 64'h0, s);
    e.full = 1'b0;
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      logic ok;
      m = sb.pop_front();
      total++;
      ok = (instr_valid === m.v) && (pc === m.pc) && (stat === m.stat);
      if (m.full)
        ok = ok && (icode === m.icode) && (ifun === m.ifun)
          && (rA === m.ra) && (rB === m.rb)
          && (valC === m.valc) && (valP === m.valp);
      if (!ok) begin
        bad++;
        $display("FAIL %s: got v=%0b pc=%0h ic=%0h fn=%0h rA=%0h rB=%0h valC=%0h valP=%0h stat=%0d want v=%0b pc=%0h ic=%0h fn=%0h rA=%0h rB=%0h valC=%0h valP=%0h stat=%0d full=%0b",
          m.name, instr_valid, pc, icode, ifun, rA, rB, valC, valP, stat,
          m.v, m.pc, m.icode, m.ifun, m.ra, m.rb, m.valc, m.valp, m.stat,
          m.full);
      end
    end
  end

  task automatic drv(input logic r, input logic s, input logic l,
    input logic [63:0] n);
    rst_n = r; stall = s; pc_load = l; pc_next = n;
  endtask

  task automatic step(input exp_t e, input string nm);
    e.name = nm;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    imem_we = 1'b1; imem_waddr = 10'(a); imem_wdata = d;
    @(posedge clk);
    @(negedge clk);
    #1;
    imem_we = 1'b0;
  endtask

  exp_t rst_e, nop_e, jxx_e;

  initial begin
    rst_e = mkf(0, 64'h0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1);
    nop_e = mkf(1, 64'h0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h1, 3'd1);
    jxx_e = mkf(1, 64'h20, 4'h7, 4'h0, 4'hF, 4'hF, 64'h40, 64'h29, 3'd1);

    @(negedge clk); #1;
    for (int i = 0; i < 'h70; i++) wr(i, 8'h00);
    wr(0, 8'h10); wr(1, 8'h30); wr(2, 8'hF3); wr(3, 8'h0A);
    wr('h0B, 8'h60); wr('h0C, 8'h03);
    wr('h20, 8'h70); wr('h21, 8'h40);
    wr('h40, 8'h20); wr('h41, 8'h12);
    wr('h42, 8'hA0); wr('h43, 8'h3F);
    wr('h44, 8'hB0); wr('h45, 8'h2F);
    wr('h46, 8'h50); wr('h47, 8'h15); wr('h48, 8'h08);
    wr('h50, 8'h80); wr('h52, 8'h01);
    wr('h59, 8'h90); wr('h5A, 8'hC0);
    wr('h3FC, 8'h30); wr('h3FD, 8'hF3);
    wr('h3FE, 8'h60); wr('h3FF, 8'h12);

    drv(0, 0, 0, 0); step(rst_e, "a_rst");
    drv(1, 0, 0, 0); step(nop_e, "a_nop");
    step(mkf(1, 64'h1, 4'h3, 4'h0, 4'hF, 4'h3, 64'hA, 64'hB, 3'd1), "a_irmov");
    drv(1, 0, 1, 64'h20);
    step(mkf(1, 64'hB, 4'h6, 4'h0, 4'h0, 4'h3, 64'h0, 64'hD, 3'd1), "a_opq");
    drv(1, 0, 1, 64'h40); step(jxx_e, "a_jxx");
    drv(1, 1, 1, 64'h100); step(jxx_e, "a_stall1"); step(jxx_e, "a_stall2");
    drv(1, 0, 0, 0);
    step(mkf(1, 64'h40, 4'h2, 4'h0, 4'h1, 4'h2, 64'h0, 64'h42, 3'd1), "a_cmov");
    step(mkf(1, 64'h42, 4'hA, 4'h0, 4'h3, 4'hF, 64'h0, 64'h44, 3'd1), "a_push");
    step(mkf(1, 64'h44, 4'hB, 4'h0, 4'h2, 4'hF, 64'h0, 64'h46, 3'd1), "a_pop");
    step(mkf(1, 64'h46, 4'h5, 4'h0, 4'h1, 4'h5, 64'h8, 64'h50, 3'd1), "a_mrmov");
    step(mkf(1, 64'h50, 4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'h59, 3'd1), "a_call");
    step(mkf(1, 64'h59, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h5A, 3'd1), "a_ret");
    step(mkp(1, 64'h5A, 3'd4), "a_ins");
    drv(1, 0, 1, 64'h10); step(mkp(0, 64'h5A, 3'd4), "a_err");
    drv(1, 1, 0, 0); step(mkp(0, 64'h5A, 3'd4), "a_err_stall");

    drv(0, 0, 0, 0); step(rst_e, "b_rst");
    drv(1, 0, 1, 64'h5); step(nop_e, "b_nop");
    drv(1, 0, 0, 0);
    step(mkf(1, 64'h5, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h6, 3'd2), "b_halt");
    drv(1, 0, 1, 64'h40); step(mkp(0, 64'h5, 3'd2), "b_hold1");
    drv(1, 1, 0, 0); step(mkp(0, 64'h5, 3'd2), "b_hold2");
    drv(1, 0, 0, 0); step(mkp(0, 64'h5, 3'd2), "b_hold3");

    drv(0, 1, 1, 64'h40); step(rst_e, "c_rst_halt");
    drv(1, 0, 0, 0);
    imem_we = 1'b1; imem_waddr = 10'h0; imem_wdata = 8'h00;
    step(nop_e, "c_wr_old");
    imem_wdata = 8'h10;
    drv(1, 1, 1, 64'h40); step(nop_e, "c_stall");
    imem_we = 1'b0;
    drv(0, 1, 1, 64'h40); step(rst_e, "c_rst_stall");

    drv(1, 0, 1, 64'h3FE); step(nop_e, "d_nop");
    drv(1, 0, 1, 64'h3FC);
    step(mkf(1, 64'h3FE, 4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h400, 3'd1), "d_edge");
    drv(1, 0, 0, 0); step(mkp(1, 64'h3FC, 3'd3), "d_adr");
    step(mkp(0, 64'h3FC, 3'd3), "d_err");

    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
